// File: rtl/mem_lsu_fsm.sv
// mem_lsu_fsm -- multi-cycle MEM-stage load/store unit on a req/ack data bus.
//
// Carries the MIPS32 byte-lane, sign-extension, LWL/LWR/SWL/SWR and LL/SC
// semantics of the single-cycle MEM stage. Accesses go over a bus with wait
// states instead of a single-cycle SRAM. The pipeline is held through
// stallreq_o while an access is outstanding. The EX/MEM register stays frozen
// during that time, so aluop_i, mem_addr_i and reg2_i are stable until the
// access completes.
//
// Build option: define MEM_ALIGN_EXC_EN to raise AdEL (0x4) / AdES (0x5) on
// misaligned halfword/word accesses. When it is undefined, word accesses
// ignore addr[1:0] and halfword accesses use only addr[1].
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   flush                    abandon any access (exception / eret)
//   aluop_i                  EXE_*_OP from EX/MEM
//   mem_addr_i, reg2_i       effective address, store data / LWL-LWR merge source
//   wd_i, wreg_i, wdata_i    writeback passthrough
//   LLbit_i, wb_LLbit_*_i    LLbit with WB-stage forwarding
//   bus_req_o .. bus_wdata_o request side of the data bus (held until ack)
//   bus_ack_i, bus_rdata_i, bus_err_i   response side (err valid with ack)
//   stallreq_o               hold IF..MEM while the access is incomplete
//   wd_o, wreg_o, wdata_o    to MEM/WB
//   LLbit_we_o, LLbit_value_o  LLbit update
//   mem_exc_o, bad_vaddr_o   0 none, 0x4 AdEL, 0x5 AdES, 0x7 bus error; faulting address
module mem_lsu_fsm #(
  parameter int ADDR_W      = 32,
  parameter bit BIG_ENDIAN  = 1'b1,
  parameter int TIMEOUT_CYC = 64,
  parameter int TO_W        = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [7:0]        aluop_i,
  input  logic [31:0]       mem_addr_i,
  input  logic [31:0]       reg2_i,
  input  logic [4:0]        wd_i,
  input  logic              wreg_i,
  input  logic [31:0]       wdata_i,
  input  logic              LLbit_i,
  input  logic              wb_LLbit_we_i,
  input  logic              wb_LLbit_value_i,
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [ADDR_W-1:0] bus_addr_o,
  output logic [3:0]        bus_sel_o,
  output logic [31:0]       bus_wdata_o,
  input  logic              bus_ack_i,
  input  logic [31:0]       bus_rdata_i,
  input  logic              bus_err_i,
  output logic              stallreq_o,
  output logic [4:0]        wd_o,
  output logic              wreg_o,
  output logic [31:0]       wdata_o,
  output logic              LLbit_we_o,
  output logic              LLbit_value_o,
  output logic [31:0]       mem_exc_o,
  output logic [31:0]       bad_vaddr_o
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LWL = 8'b1110_0010;
  localparam logic [7:0] OP_LWR = 8'b1110_0110;
  localparam logic [7:0] OP_LL  = 8'b1111_0000;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_SWL = 8'b1110_1010;
  localparam logic [7:0] OP_SWR = 8'b1110_1110;
  localparam logic [7:0] OP_SC  = 8'b1111_1000;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  function automatic logic signed [31:0] sext8(input logic signed [7:0] b);
    return 32'(b);
  endfunction

  function automatic logic signed [31:0] sext16(input logic signed [15:0] h);
    return 32'(h);
  endfunction

  // Load result from the captured bus word. off is the big-endian byte
  // offset: 0 selects bits [31:24].
  function automatic logic [31:0] load_word(input logic [7:0]  op,
                                            input logic [1:0]  off,
                                            input logic [31:0] rd,
                                            input logic [31:0] r2);
    logic [31:0] byte_sh;
    logic [15:0] half;
    byte_sh = rd >> {~off, 3'b000};
    half    = off[1] ? rd[15:0] : rd[31:16];
    case (op)
      OP_LB:   return sext8(byte_sh[7:0]);
      OP_LBU:  return {24'h0, byte_sh[7:0]};
      OP_LH:   return sext16(half);
      OP_LHU:  return {16'h0, half};
      OP_LWL: begin
        case (off)
          2'd0:    return rd;
          2'd1:    return {rd[23:0], r2[7:0]};
          2'd2:    return {rd[15:0], r2[15:0]};
          default: return {rd[7:0],  r2[23:0]};
        endcase
      end
      OP_LWR: begin
        case (off)
          2'd0:    return {r2[31:8],  rd[31:24]};
          2'd1:    return {r2[31:16], rd[31:16]};
          2'd2:    return {r2[31:24], rd[31:8]};
          default: return rd;
        endcase
      end
      default: return rd;
    endcase
  endfunction

  state_t          state_q, state_d;
  logic [TO_W-1:0] cnt_q, cnt_d;

  logic              we_p1;
  logic [ADDR_W-1:0] addr_p1;
  logic [3:0]        sel_p1;
  logic [31:0]       wdata_p1;
  logic [31:0]       rdata_p2;
  logic              err_p2;

  logic [1:0]  off;
  logic        is_load, is_store, is_mem;
  logic        llbit_eff, sc_fail;
  logic [31:0] align_exc;
  logic [3:0]  req_sel;
  logic [31:0] req_wdata;
  logic        launch, capture, err_d;
  logic [31:0] load_data;

  // Little-endian lanes are the big-endian lanes mirrored, so one offset
  // translation covers every lane and shift below.
  assign off       = BIG_ENDIAN ? mem_addr_i[1:0] : ~mem_addr_i[1:0];
  assign llbit_eff = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
  assign sc_fail   = (aluop_i == OP_SC) && !llbit_eff;
  assign load_data = load_word(aluop_i, off, rdata_p2, reg2_i);

  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    req_sel   = 4'b1111;
    req_wdata = reg2_i;
    case (aluop_i)
      OP_LB, OP_LBU: begin is_load = 1'b1; req_sel = 4'b1000 >> off; end
      OP_LH, OP_LHU: begin is_load = 1'b1; req_sel = off[1] ? 4'b0011 : 4'b1100; end
      OP_LW, OP_LWL, OP_LWR, OP_LL: is_load = 1'b1;
      OP_SB: begin
        is_store  = 1'b1;
        req_sel   = 4'b1000 >> off;
        req_wdata = {4{reg2_i[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        req_sel   = off[1] ? 4'b0011 : 4'b1100;
        req_wdata = {2{reg2_i[15:0]}};
      end
      OP_SW, OP_SC: is_store = 1'b1;
      OP_SWL: begin
        is_store  = 1'b1;
        req_sel   = 4'b1111 >> off;
        req_wdata = reg2_i >> {off, 3'b000};
      end
      OP_SWR: begin
        is_store  = 1'b1;
        req_sel   = 4'b1111 << (~off);
        req_wdata = reg2_i << {~off, 3'b000};
      end
      default: ;
    endcase
  end

  assign is_mem = is_load | is_store;

`ifdef MEM_ALIGN_EXC_EN
  always_comb begin
    align_exc = 32'h0;
    case (aluop_i)
      OP_LH, OP_LHU: if (mem_addr_i[0])          align_exc = 32'h4;
      OP_LW, OP_LL:  if (mem_addr_i[1:0] != 2'b0) align_exc = 32'h4;
      OP_SH:         if (mem_addr_i[0])          align_exc = 32'h5;
      OP_SW, OP_SC:  if (mem_addr_i[1:0] != 2'b0) align_exc = 32'h5;
      default: ;
    endcase
  end
`else
  assign align_exc = 32'h0;
`endif

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    launch        = 1'b0;
    capture       = 1'b0;
    err_d         = 1'b0;
    stallreq_o    = 1'b0;
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    mem_exc_o     = 32'h0;
    bad_vaddr_o   = 32'h0;
    if (rst) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      wd_o    = 5'h0;
      wreg_o  = 1'b0;
      wdata_o = 32'h0;
    end else if (flush) begin
      // Flush beats a same-cycle ack: the access is dropped, nothing retires.
      state_d = S_IDLE;
      cnt_d   = '0;
      wreg_o  = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (is_mem) begin
            if (align_exc != 32'h0) begin
              mem_exc_o   = align_exc;
              wreg_o      = 1'b0;
              bad_vaddr_o = mem_addr_i;
            end else if (sc_fail) begin
              // Lost reservation: SC completes here without touching the bus.
              wdata_o = 32'h0;
            end else begin
              stallreq_o = 1'b1;
              wreg_o     = 1'b0;
              launch     = 1'b1;
              cnt_d      = '0;
              state_d    = S_BUSY;
            end
          end
        end
        S_BUSY: begin
          stallreq_o = 1'b1;
          wreg_o     = 1'b0;
          if (bus_ack_i) begin
            capture = 1'b1;
            err_d   = bus_err_i;
            cnt_d   = '0;
            state_d = S_DONE;
          end else if (cnt_q == TO_W'(TIMEOUT_CYC - 1)) begin
            err_d   = 1'b1;
            cnt_d   = '0;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + TO_W'(1);
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
          if (err_p2) begin
            mem_exc_o   = 32'h7;
            wreg_o      = 1'b0;
            bad_vaddr_o = mem_addr_i;
          end else if (aluop_i == OP_SC) begin
            wdata_o       = 32'h1;
            LLbit_we_o    = 1'b1;
            LLbit_value_o = 1'b0;
          end else if (is_load) begin
            wdata_o = load_data;
            if (aluop_i == OP_LL) begin
              LLbit_we_o    = 1'b1;
              LLbit_value_o = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      we_p1    <= 1'b0;
      addr_p1  <= '0;
      sel_p1   <= 4'h0;
      wdata_p1 <= 32'h0;
      rdata_p2 <= 32'h0;
      err_p2   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      // p1: request fields frozen for the whole BUSY phase
      if (launch) begin
        we_p1    <= is_store;
        addr_p1  <= ADDR_W'({mem_addr_i[31:2], 2'b00});
        sel_p1   <= req_sel;
        wdata_p1 <= req_wdata;
      end
      // p2: response captured for the DONE cycle
      if (capture) rdata_p2 <= bus_rdata_i;
      if (state_q == S_BUSY && state_d == S_DONE) err_p2 <= err_d;
    end
  end

  assign bus_req_o   = (state_q == S_BUSY);
  assign bus_we_o    = we_p1;
  assign bus_addr_o  = addr_p1;
  assign bus_sel_o   = sel_p1;
  assign bus_wdata_o = wdata_p1;

endmodule
